// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word geometry, the round constant table and the
// small/large sigma functions used by the schedule and the round datapath.
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int BLK_WORDS = 16;
    localparam int ROUNDS    = 64;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    localparam word_t K_TABLE [0:ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t sig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup, shared with unrolled round variants.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0] idx,
    output word_t      k
);

    assign k = K_TABLE[idx];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule producer: loads a 512-bit block into a 16-word
// sliding window and streams (W_t, K_t, t) for t = 0..63 over valid/ready.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [31:0]  k_out,
    output logic [5:0]   t_out,
    output logic         w_last
);

    sched_state_e state_r;
    logic [5:0]   t_r;
    word_t        win_r [0:BLK_WORDS-1];
    word_t        w_new_s;
    logic         last_s;
    logic         blk_ready_s;

    assign last_s  = (state_r == ST_RUN) && (t_r == 6'd63);
    assign w_new_s = sig1(win_r[14]) + win_r[9] + sig0(win_r[1]) + win_r[0];

    // Block slot opens in IDLE, or on the cycle the last word is being taken.
    always_comb begin
        blk_ready_s = 1'b0;
        if (rst) begin
            blk_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: blk_ready_s = 1'b1;
                ST_RUN:  blk_ready_s = last_s ? w_ready : 1'b0;
                default: blk_ready_s = 1'b0;
            endcase
        end
    end

    // Sequencer, round counter and window shift/expansion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            t_r     <= 6'd0;
            for (int j = 0; j < BLK_WORDS; j++) begin
                win_r[j] <= 32'h0000_0000;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (blk_valid) begin
                        for (int j = 0; j < BLK_WORDS; j++) begin
                            win_r[j] <= blk_data[511-32*j -: 32];
                        end
                        t_r     <= 6'd0;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_ready) begin
                        if (t_r == 6'd63) begin
                            // Reload straight from the last beat so blocks run back-to-back.
                            if (blk_valid) begin
                                for (int j = 0; j < BLK_WORDS; j++) begin
                                    win_r[j] <= blk_data[511-32*j -: 32];
                                end
                                t_r <= 6'd0;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            for (int j = 0; j < BLK_WORDS-1; j++) begin
                                win_r[j] <= win_r[j+1];
                            end
                            win_r[BLK_WORDS-1] <= w_new_s;
                            t_r                <= t_r + 6'd1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    sha256_k_rom u_k_rom (
        .idx (t_r),
        .k   (k_out)
    );

    assign blk_ready = blk_ready_s;
    assign w_valid   = (state_r == ST_RUN);
    assign w_last    = last_s;
    assign w_out     = win_r[0];
    assign t_out     = t_r;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched against an array-based FIPS 180-4
// schedule model with random blocks and random backpressure.
module tb_sha256_msg_sched;

    typedef logic [63:0][31:0] wvec_t;

    localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] ONES_BLK = {512{1'b1}};

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [31:0]  k_out;
    logic [5:0]   t_out;
    logic         w_last;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] got_w [64];

    always #5 clk = ~clk;

    sha256_msg_sched dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_out     (w_out),
        .k_out     (k_out),
        .t_out     (t_out),
        .w_last    (w_last)
    );

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: W_t straight from the FIPS 180-4 recurrence over a full array.
    function automatic wvec_t schedule(input logic [511:0] b);
        wvec_t w;
        for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        return w;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input logic [511:0] b);
        bit done = 1'b0;
        blk_data  = b;
        blk_valid = 1'b1;
        #1;
        for (int n = 0; n < 100 && !done; n++) begin
            if (blk_ready === 1'b1) done = 1'b1;
            step();
        end
        blk_valid = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL load_block: blk_ready never rose (got %b, need 1)", blk_ready);
        end
    endtask

    // Consume words idx = from..upto-1 at the given w_ready duty (percent).
    task automatic drain(input wvec_t e, input int from, input int upto, input int duty);
        int idx = from;
        int budget = 0;
        logic exp_br;
        while (idx < upto && budget < 4000) begin
            w_ready = ($urandom_range(99) < duty);
            #1;
            vectors++;
            if (w_valid !== 1'b1 || t_out !== idx[5:0] || w_out !== e[idx] ||
                k_out !== KT[idx] || w_last !== (idx == 63)) begin
                miscompares++;
                $display("FAIL word t=%0d: got v=%b t=%0d w=%h k=%h last=%b, need v=1 t=%0d w=%h k=%h last=%b",
                         idx, w_valid, t_out, w_out, k_out, w_last, idx, e[idx], KT[idx], idx == 63);
            end
            exp_br = (idx == 63) && w_ready;
            vectors++;
            if (blk_ready !== exp_br) begin
                miscompares++;
                $display("FAIL blk_ready t=%0d: got %b, need %b", idx, blk_ready, exp_br);
            end
            got_w[idx] = w_out;
            step();
            if (w_ready) idx++;
            budget++;
        end
        w_ready = 1'b0;
        vectors++;
        if (idx < upto) begin
            miscompares++;
            $display("FAIL drain timeout: reached t=%0d, need %0d", idx, upto);
        end
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if (w_valid !== 1'b0 || w_last !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got w_valid=%b w_last=%b, need 0 0", name, w_valid, w_last);
        end
    endtask

    task automatic check_word(input string name, input int t, input logic [31:0] exp);
        vectors++;
        if (got_w[t] !== exp) begin
            miscompares++;
            $display("FAIL %s: W_%0d got %h, need %h", name, t, got_w[t], exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; blk_valid = 1'b1; w_ready = 1'b1; blk_data = ABC_BLK;
        step(); step();
        vectors++;
        if (w_valid !== 1'b0 || w_last !== 1'b0 || t_out !== 6'd0 ||
            w_out !== 32'h0 || k_out !== 32'h428a2f98 || blk_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got v=%b last=%b t=%0d w=%h k=%h br=%b, need 0 0 0 0 428a2f98 0",
                     w_valid, w_last, t_out, w_out, k_out, blk_ready);
        end
        blk_valid = 1'b0; w_ready = 1'b0;
        rst = 1'b0;
        #1;
        vectors++;
        if (blk_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: blk_ready got %b, need 1", blk_ready);
        end
    endtask

    task automatic test_abc();
        load_block(ABC_BLK);
        drain(schedule(ABC_BLK), 0, 64, 100);
        check_idle("abc_end");
        check_word("abc", 0, 32'h61626380);
        check_word("abc", 14, 32'h00000000);
        check_word("abc", 15, 32'h00000018);
        check_word("abc", 16, 32'h61626380);
        check_word("abc", 17, 32'h000f0000);
    endtask

    task automatic test_all_ones();
        load_block(ONES_BLK);
        drain(schedule(ONES_BLK), 0, 64, 100);
        check_idle("ones_end");
        check_word("ones", 0, 32'hffffffff);
        check_word("ones", 16, 32'h203ffffc);
    endtask

    task automatic test_backpressure();
        logic [511:0] b;
        load_block(ABC_BLK);
        drain(schedule(ABC_BLK), 0, 64, 50);
        check_idle("bp_abc_end");
        for (int r = 0; r < 3; r++) begin
            b = rand_blk();
            load_block(b);
            drain(schedule(b), 0, 64, 50);
            check_idle("bp_rand_end");
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] a, b;
        a = rand_blk();
        b = rand_blk();
        blk_data = a; blk_valid = 1'b1;
        #1;
        vectors++;
        if (blk_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept: blk_ready got %b, need 1", blk_ready);
        end
        step();
        blk_data = b;
        drain(schedule(a), 0, 64, 100);
        blk_valid = 1'b0;
        drain(schedule(b), 0, 64, 100);
        check_idle("b2b_end");
    endtask

    task automatic test_reset_mid();
        load_block(ABC_BLK);
        drain(schedule(ABC_BLK), 0, 20, 100);
        w_ready = 1'b1;
        rst = 1'b1;
        step();
        check_idle("rst_mid");
        vectors++;
        if (blk_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_ready: blk_ready got %b, need 0", blk_ready);
        end
        rst = 1'b0; w_ready = 1'b0;
        #1;
        vectors++;
        if (blk_ready !== 1'b1 || w_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_idle: got br=%b v=%b, need 1 0", blk_ready, w_valid);
        end
        load_block(ABC_BLK);
        drain(schedule(ABC_BLK), 0, 64, 100);
        check_idle("rst_mid_end");
        check_word("rst_mid", 0, 32'h61626380);
    endtask

    task automatic test_mid_block_valid();
        logic [511:0] a, b;
        a = rand_blk();
        b = rand_blk();
        load_block(a);
        drain(schedule(a), 0, 10, 100);
        blk_data = b; blk_valid = 1'b1;
        drain(schedule(a), 10, 64, 70);
        blk_valid = 1'b0;
        drain(schedule(b), 0, 64, 60);
        check_idle("mid_valid_end");
    endtask

    initial begin
        test_reset();
        test_abc();
        test_all_ones();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_mid_block_valid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
